// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: the decoder (master) presents the instruction
// in D, and the scoreboard (slave) answers with stall and forwarding selects.
// Handshake: there is no valid/ready pair here. d_valid qualifies every D
// field in the same cycle, and stall is the back-pressure that holds D.
// An instruction leaves D on a rising edge where d_valid=1, stall=0 and
// flush=0.
interface hazard_scoreboard_if #(
    parameter int NREG_W = 5,
    parameter int T_W    = 2
);
    logic              d_valid;
    logic [NREG_W-1:0] d_rs;
    logic [NREG_W-1:0] d_rt;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic [NREG_W-1:0] d_wa;
    logic [T_W-1:0]    d_tnew;
    logic              d_md_start;
    logic              d_is_div;
    logic              d_md_use;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_rs;
    logic [1:0]        fwd_rt;
    logic              md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_is_div, d_md_use, flush,
        input  stall, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_is_div, d_md_use, flush,
        output stall, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit for the 5-stage MIPS pipeline. It tracks the pending
// destination register in E, M and W, and derives the D-stage stall and the
// rs/rt forwarding selects from them. It also owns the mult/div busy counter.
module hazard_scoreboard #(
    parameter int NREG_W     = 5,
    parameter int T_W        = 2,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    logic [NREG_W-1:0] e_addr, m_addr, w_addr;
    logic [T_W-1:0]    e_tnew, m_tnew, w_tnew;
    logic [CNT_W-1:0]  cnt;

    logic              rs_stall, rt_stall;
    logic [1:0]        rs_fwd, rt_fwd;
    logic              stall_int;
    logic              md_busy_int;
    logic              e_load;
    logic              md_load;

    // Returns {stall, fwd}. The youngest matching stage decides. Register 0
    // and unused sources (tuse all-ones) never create a hazard.
    function automatic logic [2:0] resolve(
        input logic [NREG_W-1:0] src,
        input logic [T_W-1:0]    tuse,
        input logic              valid,
        input logic [NREG_W-1:0] ea, ma, wa,
        input logic [T_W-1:0]    et, mt, wt
    );
        logic [2:0] r;
        r = 3'b000;
        if (valid && (src != '0) && (tuse != '1)) begin
            if (src == ea)      r = (et > tuse) ? 3'b100 : 3'b001;
            else if (src == ma) r = (mt > tuse) ? 3'b100 : 3'b010;
            else if (src == wa) r = (wt > tuse) ? 3'b100 : 3'b011;
        end
        return r;
    endfunction

    // Combinational hazard decision from the current entries and D fields.
    always_comb begin
        {rs_stall, rs_fwd} = resolve(bus.d_rs, bus.d_tuse_rs, bus.d_valid,
                                     e_addr, m_addr, w_addr,
                                     e_tnew, m_tnew, w_tnew);
        {rt_stall, rt_fwd} = resolve(bus.d_rt, bus.d_tuse_rt, bus.d_valid,
                                     e_addr, m_addr, w_addr,
                                     e_tnew, m_tnew, w_tnew);
        md_busy_int = (cnt != '0);
        stall_int   = rs_stall | rt_stall | (bus.d_valid & bus.d_md_use & md_busy_int);
        // flush wins over a stall: neither E nor the counter loads.
        e_load      = bus.d_valid & ~stall_int & ~bus.flush;
        md_load     = e_load & bus.d_md_start;
    end

    assign bus.stall   = stall_int;
    assign bus.fwd_rs  = rs_fwd;
    assign bus.fwd_rt  = rt_fwd;
    assign bus.md_busy = md_busy_int;

    // Advance E->M->W every edge. Tnew drops by one, saturating, on leaving E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_addr <= '0;
            e_tnew <= '0;
            m_addr <= '0;
            m_tnew <= '0;
            w_addr <= '0;
            w_tnew <= '0;
        end else begin
            w_addr <= m_addr;
            w_tnew <= m_tnew;
            m_addr <= e_addr;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - T_W'(1);
            if (e_load) begin
                e_addr <= bus.d_wa;
                e_tnew <= bus.d_tnew;
            end else begin
                e_addr <= '0;
                e_tnew <= '0;
            end
        end
    end

    // Mult/div busy counter: it loads on an accepted start and counts down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (md_load) begin
            cnt <= bus.d_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Directed scenarios cover the pipeline timing
// cases. A randomized run is scored against an age-based model: each issued
// slot remembers its original Tnew and how many edges ago it issued.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    hazard_scoreboard_if #(.NREG_W(5), .T_W(2)) bus ();

    hazard_scoreboard #(
        .NREG_W(5), .T_W(2), .MUL_CYCLES(5), .DIV_CYCLES(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.d_valid    = 1'b0;
        bus.d_rs       = '0;
        bus.d_rt       = '0;
        bus.d_tuse_rs  = 2'd3;
        bus.d_tuse_rt  = 2'd3;
        bus.d_wa       = '0;
        bus.d_tnew     = '0;
        bus.d_md_start = 1'b0;
        bus.d_is_div   = 1'b0;
        bus.d_md_use   = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] addr;
        logic [1:0] tnew0;
    } rec_t;
    rec_t hist[$];       // hist[k] issued k edges ago; k=0 is E, 1 is M, 2 is W
    int   edge_n;
    int   busy_until;

    task automatic model_clear();
        rec_t z;
        z.addr  = '0;
        z.tnew0 = '0;
        hist.delete();
        repeat (3) hist.push_back(z);
        busy_until = 0;
    endtask

    // A result is one cycle nearer once it has left E. It is not aged further after that.
    function automatic void model_src(input logic [4:0] s, input logic [1:0] tuse,
                                      input logic valid, output logic st,
                                      output logic [1:0] fw);
        int eff;
        st = 1'b0;
        fw = 2'd0;
        if (valid && s != 0 && tuse != 2'd3) begin
            for (int k = 0; k < 3; k++) begin
                if (hist[k].addr == s) begin
                    eff = int'(hist[k].tnew0);
                    if (k > 0 && eff > 0) eff = eff - 1;
                    if (eff > int'(tuse)) st = 1'b1;
                    else fw = 2'(k + 1);
                    break;
                end
            end
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        bus.d_valid  = 1'b1;
        bus.d_rs     = 5'd5;
        bus.d_rt     = 5'd6;
        bus.d_tuse_rs = 2'd0;
        bus.d_tuse_rt = 2'd0;
        bus.d_md_use = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        compared += 4;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL reset_fwd_rs got=%0d want=0", bus.fwd_rs); end
        if (bus.fwd_rt !== 2'd0) begin mismatched++; $display("FAIL reset_fwd_rt got=%0d want=0", bus.fwd_rt); end
        if (bus.md_busy !== 1'b0) begin mismatched++; $display("FAIL reset_md_busy got=%b want=0", bus.md_busy); end
        set_idle();
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd8; bus.d_tnew = 2'd2;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rs = 5'd8; bus.d_tuse_rs = 2'd1;
        #1;
        compared += 2;
        if (bus.stall !== 1'b1) begin mismatched++; $display("FAIL load_use_stall got=%b want=1", bus.stall); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL load_use_fwd0 got=%0d want=0", bus.fwd_rs); end
        @(negedge clk);
        #1;
        compared += 2;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL load_use_release got=%b want=0", bus.stall); end
        if (bus.fwd_rs !== 2'd2) begin mismatched++; $display("FAIL load_use_fwd_m got=%0d want=2", bus.fwd_rs); end
    endtask

    task automatic test_alu_use();
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd9; bus.d_tnew = 2'd1;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rt = 5'd9; bus.d_tuse_rt = 2'd0;
        #1;
        compared += 1;
        if (bus.stall !== 1'b1) begin mismatched++; $display("FAIL alu_use_stall got=%b want=1", bus.stall); end
        @(negedge clk);
        #1;
        compared += 2;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL alu_use_release got=%b want=0", bus.stall); end
        if (bus.fwd_rt !== 2'd2) begin mismatched++; $display("FAIL alu_use_fwd_rt got=%0d want=2", bus.fwd_rt); end
    endtask

    task automatic test_e_priority();
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd10; bus.d_tnew = 2'd0;
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd10; bus.d_tnew = 2'd0;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rs = 5'd10; bus.d_tuse_rs = 2'd0;
        #1;
        compared += 2;
        if (bus.fwd_rs !== 2'd1) begin mismatched++; $display("FAIL e_priority_fwd got=%0d want=1", bus.fwd_rs); end
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL e_priority_stall got=%b want=0", bus.stall); end
    endtask

    task automatic test_div_busy();
        int busy_cycles;
        int stall_cycles;
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_md_start = 1'b1; bus.d_is_div = 1'b1; bus.d_md_use = 1'b1;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_md_use = 1'b1;
        busy_cycles = 0;
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (bus.stall === 1'b1) stall_cycles++;
            if (bus.md_busy !== 1'b1) break;
            busy_cycles++;
        end
        compared += 4;
        if (busy_cycles != 10) begin mismatched++; $display("FAIL div_busy_len got=%0d want=10", busy_cycles); end
        if (stall_cycles != 10) begin mismatched++; $display("FAIL div_stall_len got=%0d want=10", stall_cycles); end
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL div_stall_end got=%b want=0", bus.stall); end
        if (bus.md_busy !== 1'b0) begin mismatched++; $display("FAIL div_busy_end got=%b want=0", bus.md_busy); end
    endtask

    task automatic test_zero_and_flush();
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd0; bus.d_tnew = 2'd2;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rs = 5'd0; bus.d_tuse_rs = 2'd0;
        #1;
        compared += 2;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL zero_reg_stall got=%b want=0", bus.stall); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL zero_reg_fwd got=%0d want=0", bus.fwd_rs); end
        // flush while a lw-use is stalled; the flushed div with wa=12 must not issue
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_wa = 5'd8; bus.d_tnew = 2'd2;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rs = 5'd8; bus.d_tuse_rs = 2'd1;
        bus.d_wa = 5'd12; bus.d_tnew = 2'd2;
        bus.d_md_start = 1'b1; bus.d_is_div = 1'b1; bus.d_md_use = 1'b1; bus.flush = 1'b1;
        #1;
        compared += 1;
        if (bus.stall !== 1'b1) begin mismatched++; $display("FAIL flush_stall_pre got=%b want=1", bus.stall); end
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_md_use = 1'b1;
        bus.d_rs = 5'd12; bus.d_tuse_rs = 2'd0;
        bus.d_rt = 5'd8;  bus.d_tuse_rt = 2'd1;
        #1;
        compared += 4;
        if (bus.md_busy !== 1'b0) begin mismatched++; $display("FAIL flush_cnt_loaded got=%b want=0", bus.md_busy); end
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL flush_e_bubble_stall got=%b want=0", bus.stall); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL flush_e_bubble_fwd got=%0d want=0", bus.fwd_rs); end
        if (bus.fwd_rt !== 2'd2) begin mismatched++; $display("FAIL flush_m_advance got=%0d want=2", bus.fwd_rt); end
        // an unstalled flush must drop its write and its mult start
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_wa = 5'd11; bus.d_tnew = 2'd2;
        bus.d_md_start = 1'b1; bus.d_md_use = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_md_use = 1'b1; bus.d_rs = 5'd11; bus.d_tuse_rs = 2'd0;
        #1;
        compared += 3;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL flush_free_stall got=%b want=0", bus.stall); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL flush_free_fwd got=%0d want=0", bus.fwd_rs); end
        if (bus.md_busy !== 1'b0) begin mismatched++; $display("FAIL flush_free_busy got=%b want=0", bus.md_busy); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_md_start = 1'b1; bus.d_is_div = 1'b1; bus.d_md_use = 1'b1;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        @(negedge clk);
        bus.d_valid = 1'b1; bus.d_wa = 5'd5; bus.d_tnew = 2'd2;
        @(negedge clk);
        set_idle();
        bus.d_valid = 1'b1; bus.d_rs = 5'd5; bus.d_tuse_rs = 2'd1; bus.d_md_use = 1'b1;
        #1;
        compared += 2;
        if (bus.stall !== 1'b1) begin mismatched++; $display("FAIL async_pre_stall got=%b want=1", bus.stall); end
        if (bus.md_busy !== 1'b1) begin mismatched++; $display("FAIL async_pre_busy got=%b want=1", bus.md_busy); end
        #1;
        reset = 1'b0;
        #1;
        compared += 3;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL async_stall got=%b want=0", bus.stall); end
        if (bus.md_busy !== 1'b0) begin mismatched++; $display("FAIL async_busy got=%b want=0", bus.md_busy); end
        if (bus.fwd_rs !== 2'd0) begin mismatched++; $display("FAIL async_fwd got=%0d want=0", bus.fwd_rs); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        compared += 1;
        if (bus.stall !== 1'b0) begin mismatched++; $display("FAIL async_after_release got=%b want=0", bus.stall); end
    endtask

    task automatic test_random();
        logic       s1, s2, exp_stall, exp_busy, accepted;
        logic [1:0] f1, f2;
        rec_t       r;
        apply_reset();
        model_clear();
        edge_n = 0;
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.d_valid    = ($urandom_range(0, 7) != 0);
            bus.d_rs       = 5'($urandom_range(0, 4));
            bus.d_rt       = 5'($urandom_range(0, 4));
            bus.d_tuse_rs  = 2'($urandom_range(0, 3));
            bus.d_tuse_rt  = 2'($urandom_range(0, 3));
            bus.d_wa       = 5'($urandom_range(0, 4));
            bus.d_tnew     = 2'($urandom_range(0, 3));
            bus.d_md_start = ($urandom_range(0, 11) == 0);
            bus.d_is_div   = 1'($urandom_range(0, 1));
            bus.d_md_use   = bus.d_md_start | ($urandom_range(0, 5) == 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
            #1;
            model_src(bus.d_rs, bus.d_tuse_rs, bus.d_valid, s1, f1);
            model_src(bus.d_rt, bus.d_tuse_rt, bus.d_valid, s2, f2);
            exp_busy  = (edge_n < busy_until);
            exp_stall = s1 | s2 | (bus.d_valid & bus.d_md_use & exp_busy);
            compared += 4;
            if (bus.stall !== exp_stall) begin mismatched++; $display("FAIL rand_stall cyc=%0d got=%b want=%b", i, bus.stall, exp_stall); end
            if (bus.fwd_rs !== f1) begin mismatched++; $display("FAIL rand_fwd_rs cyc=%0d got=%0d want=%0d", i, bus.fwd_rs, f1); end
            if (bus.fwd_rt !== f2) begin mismatched++; $display("FAIL rand_fwd_rt cyc=%0d got=%0d want=%0d", i, bus.fwd_rt, f2); end
            if (bus.md_busy !== exp_busy) begin mismatched++; $display("FAIL rand_md_busy cyc=%0d got=%b want=%b", i, bus.md_busy, exp_busy); end
            accepted = bus.d_valid & ~exp_stall & ~bus.flush;
            r.addr  = accepted ? bus.d_wa : 5'd0;
            r.tnew0 = accepted ? bus.d_tnew : 2'd0;
            @(posedge clk);
            edge_n++;
            hist.push_front(r);
            void'(hist.pop_back());
            if (accepted && bus.d_md_start) busy_until = edge_n + (bus.d_is_div ? 10 : 5);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_alu_use();
        test_e_priority();
        test_div_busy();
        test_zero_and_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
